// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
package alu_seq_pkg;

  localparam int unsigned OP_W = 4;

  // Bit positions inside rsp_flags.
  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_O = 2;
  localparam int unsigned FLAG_G = 3;
  localparam int unsigned FLAG_L = 4;
  localparam int unsigned FLAG_E = 5;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

endpackage

// File: rtl/alu_op_sequencer.sv
// Command/response front end for the registered ALU: holds operands and select lines, waits
// out the ALU latency, captures result and flags. Optional ALU_CHAIN_EN adds result chaining.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
`ifdef ALU_CHAIN_EN
  input  logic              cmd_chain,
`endif
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_s3,
  output logic              alu_s2,
  output logic              alu_s1,
  output logic              alu_s0,
  input  logic [DATA_W-1:0] alu_f,
  input  logic              alu_z,
  input  logic              alu_c,
  input  logic              alu_o,
  input  logic              alu_g,
  input  logic              alu_l,
  input  logic              alu_e,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_f,
  output logic [5:0]        rsp_flags,
  output logic              busy
);

  localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept;
  logic        capture;
  logic        rsp_done;
  logic [DATA_W-1:0] a_sel;

  assign cmd_ready = (state_q == StIdle) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state_q != StIdle);

`ifdef ALU_CHAIN_EN
  logic [DATA_W-1:0] last_f_q;
  assign a_sel = cmd_chain ? last_f_q : cmd_a;
`else
  assign a_sel = cmd_a;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    capture  = 1'b0;
    rsp_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StWait;
          cnt_d   = WaitLoad;
        end
      end
      StWait: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          capture = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_valid && rsp_ready) begin
          rsp_done = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_s3    <= 1'b0;
      alu_s2    <= 1'b0;
      alu_s1    <= 1'b0;
      alu_s0    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_f     <= '0;
      rsp_flags <= '0;
    end else begin
      // Operand and select lines only move on accept so the ALU sees them stable.
      if (accept) begin
        alu_a  <= a_sel;
        alu_b  <= cmd_b;
        alu_s3 <= cmd_op[3];
        alu_s2 <= cmd_op[2];
        alu_s1 <= cmd_op[1];
        alu_s0 <= cmd_op[0];
      end
      if (capture) begin
        rsp_f     <= alu_f;
        rsp_flags <= {alu_e, alu_l, alu_g, alu_o, alu_c, alu_z};
        rsp_valid <= 1'b1;
      end else if (rsp_done) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_CHAIN_EN
  // Tracks every capture, independent of when the response is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_f_q <= '0;
    end else if (capture) begin
      last_f_q <= alu_f;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized self-checking bench for alu_op_sequencer with a registered ALU stub.
// Define ALU_CHAIN_EN to also exercise result chaining.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned WC = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [3:0]    cmd_op;
  logic [DW-1:0] cmd_a, cmd_b;
`ifdef ALU_CHAIN_EN
  logic          cmd_chain;
`endif
  logic [DW-1:0] alu_a, alu_b, alu_f;
  logic          alu_s3, alu_s2, alu_s1, alu_s0;
  logic          alu_z, alu_c, alu_o, alu_g, alu_l, alu_e;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_f;
  logic [5:0]    rsp_flags;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] last_f;     // model of the last captured result
  logic [7:0] got_f;
  logic [5:0] got_flags;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DATA_W(DW), .WAIT_CYCLES(WC)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
`ifdef ALU_CHAIN_EN
    .cmd_chain (cmd_chain),
`endif
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_s3    (alu_s3),
    .alu_s2    (alu_s2),
    .alu_s1    (alu_s1),
    .alu_s0    (alu_s0),
    .alu_f     (alu_f),
    .alu_z     (alu_z),
    .alu_c     (alu_c),
    .alu_o     (alu_o),
    .alu_g     (alu_g),
    .alu_l     (alu_l),
    .alu_e     (alu_e),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_f     (rsp_f),
    .rsp_flags (rsp_flags),
    .busy      (busy)
  );

  // Stub ALU: op[2:0] selects add/sub/and/or/xor/passA/notA/incA; bit 8 is carry/borrow.
  function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] op);
    logic [8:0] r;
    case (op[2:0])
      3'd0: r = {1'b0, a} + {1'b0, b};
      3'd1: r = {1'b0, a} - {1'b0, b};
      3'd2: r = {1'b0, a & b};
      3'd3: r = {1'b0, a | b};
      3'd4: r = {1'b0, a ^ b};
      3'd5: r = {1'b0, a};
      3'd6: r = {1'b0, ~a};
      default: r = {1'b0, a} + 9'd1;
    endcase
    return r;
  endfunction

  function automatic logic [5:0] flags_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] op);
    logic [8:0] r;
    logic       ov;
    r  = alu_fn(a, b, op);
    ov = 1'b0;
    if (op[2:0] == 3'd0) ov = (a[7] == b[7]) && (r[7] != a[7]);
    if (op[2:0] == 3'd1) ov = (a[7] != b[7]) && (r[7] != a[7]);
    return {a == b, a < b, a > b, ov, r[8], r[7:0] == 8'd0};
  endfunction

  logic [3:0] sel;
  logic [8:0] stub_r;
  logic [5:0] stub_flags;
  assign sel        = {alu_s3, alu_s2, alu_s1, alu_s0};
  assign stub_r     = alu_fn(alu_a, alu_b, sel);
  assign stub_flags = flags_fn(alu_a, alu_b, sel);
  assign {alu_e, alu_l, alu_g, alu_o, alu_c, alu_z} = stub_flags;

  always_ff @(posedge clk) alu_f <= stub_r[7:0];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; hold = cycles rsp_ready stays low after rsp_valid.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                       input bit chain, input int hold, input bit noise);
    logic [7:0] a_eff;
    logic [8:0] r;
    logic [5:0] fl;
    int         n;
    int         lat;
`ifdef ALU_CHAIN_EN
    a_eff = chain ? last_f : a;
`else
    a_eff = a;
`endif
    r  = alu_fn(a_eff, b, op);
    fl = flags_fn(a_eff, b, op);
    n = 0;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    check_eq("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
`ifdef ALU_CHAIN_EN
    cmd_chain = chain;
`endif
    step();
    // Optional stray command during WAIT/RESP that must not be consumed.
    cmd_valid = noise;
    cmd_a     = ~a;
    cmd_b     = ~b;
    cmd_op    = ~op;
    check_eq("alu_a", 32'(alu_a), 32'(a_eff));
    check_eq("alu_b", 32'(alu_b), 32'(b));
    check_eq("alu_sel", 32'(sel), 32'(op));
    check_eq("busy_wait", 32'(busy), 32'd1);
    check_eq("cmd_ready_wait", 32'(cmd_ready), 32'd0);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      step();
      lat++;
    end
    check_eq("latency", 32'(lat), 32'(WC + 2));
    check_eq("rsp_f", 32'(rsp_f), 32'(r[7:0]));
    check_eq("rsp_flags", 32'(rsp_flags), 32'(fl));
    got_f     = rsp_f;
    got_flags = rsp_flags;
    last_f    = r[7:0];
    for (int i = 0; i < hold; i++) begin
      step();
      check_eq("hold_valid", 32'(rsp_valid), 32'd1);
      check_eq("hold_f", 32'(rsp_f), 32'(r[7:0]));
      check_eq("hold_flags", 32'(rsp_flags), 32'(fl));
      check_eq("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      check_eq("hold_alu_a", 32'(alu_a), 32'(a_eff));
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    check_eq("rsp_valid_clr", 32'(rsp_valid), 32'd0);
    check_eq("cmd_ready_back", 32'(cmd_ready), 32'd1);
    check_eq("busy_idle", 32'(busy), 32'd0);
    check_eq("alu_b_held", 32'(alu_b), 32'(b));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_op    = '0;
    rsp_ready = 1'b0;
`ifdef ALU_CHAIN_EN
    cmd_chain = 1'b0;
`endif
    last_f    = '0;
    step();
    step();
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("rst_alu_a", 32'(alu_a), 32'd0);
    check_eq("rst_alu_b", 32'(alu_b), 32'd0);
    check_eq("rst_sel", 32'(sel), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_f", 32'(rsp_f), 32'd0);
    check_eq("rst_rsp_flags", 32'(rsp_flags), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_cmd_ready_rel", 32'(cmd_ready), 32'd1);

    do_op(8'h12, 8'h34, 4'h0, 1'b0, 0, 1'b0);
    check_eq("add_f", 32'(got_f), 32'h46);
    check_eq("add_z", 32'(got_flags[FLAG_Z]), 32'd0);
    check_eq("add_c", 32'(got_flags[FLAG_C]), 32'd0);

    do_op(8'hFF, 8'h01, 4'h0, 1'b0, 0, 1'b0);
    check_eq("wrap_f", 32'(got_f), 32'h00);
    check_eq("wrap_z", 32'(got_flags[FLAG_Z]), 32'd1);
    check_eq("wrap_c", 32'(got_flags[FLAG_C]), 32'd1);
    check_eq("wrap_g", 32'(got_flags[FLAG_G]), 32'd1);

    // Long backpressure with a second command waiting.
    do_op(8'h21, 8'h0F, 4'h1, 1'b0, 10, 1'b1);

    do_op(8'h55, 8'h55, 4'h4, 1'b0, 1, 1'b0);
    check_eq("eq_e", 32'(got_flags[FLAG_E]), 32'd1);
    check_eq("eq_g", 32'(got_flags[FLAG_G]), 32'd0);
    check_eq("eq_l", 32'(got_flags[FLAG_L]), 32'd0);
    do_op(8'h10, 8'h20, 4'h2, 1'b0, 0, 1'b0);
    check_eq("lt_l", 32'(got_flags[FLAG_L]), 32'd1);

    // Reset one cycle into WAIT aborts the op.
    cmd_valid = 1'b1;
    cmd_a     = 8'h77;
    cmd_b     = 8'h66;
    cmd_op    = 4'h3;
    step();
    cmd_valid = 1'b0;
    rst       = 1'b1;
    #1;
    check_eq("abort_cmd_ready_in_rst", 32'(cmd_ready), 32'd0);
    step();
    rst    = 1'b0;
    last_f = '0;
    #1;
    check_eq("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("abort_alu_a", 32'(alu_a), 32'd0);
    check_eq("abort_alu_b", 32'(alu_b), 32'd0);
    check_eq("abort_sel", 32'(sel), 32'd0);
    check_eq("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq("abort_no_rsp", 32'(rsp_valid), 32'd0);
    end

`ifdef ALU_CHAIN_EN
    do_op(8'h09, 8'h01, 4'h0, 1'b1, 0, 1'b0);
    check_eq("chain_after_rst", 32'(got_f), 32'h01);
    do_op(8'h03, 8'h04, 4'h0, 1'b0, 0, 1'b0);
    check_eq("chain_first", 32'(got_f), 32'h07);
    do_op(8'hAA, 8'h01, 4'h0, 1'b1, 0, 1'b0);
    check_eq("chain_second", 32'(got_f), 32'h08);
`endif

    for (int k = 0; k < 40; k++) begin
      do_op(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Command-side initiator for the 8-bit registered ALU top.
- Accepts one operation (opcode plus operands) over a valid/ready command port and drives the ALU operand and select lines.
- Holds those lines stable for the ALU latency, then captures the registered result and the flags.
- Returns result and flags over a valid/ready response port. This lets a controller issue ALU operations without hand-timing the select lines.

Parameters:
DATA_W, 8, operand and result width; must match the ALU.
WAIT_CYCLES, 1, ALU output-register latency in cycles; legal range 1..15; 0 is illegal.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  4  ALU select; bit3..bit0 map to S3,S2,S1,S0
cmd_a  input  DATA_W  operand A
cmd_b  input  DATA_W  operand B
alu_a  output  DATA_W  to ALU A
alu_b  output  DATA_W  to ALU B
alu_s3, alu_s2, alu_s1, alu_s0  output  1 each  to ALU select
alu_f  input  DATA_W  ALU registered result F
alu_z, alu_c, alu_o, alu_g, alu_l, alu_e  input  1 each  ALU flags
rsp_valid  output  1  response present
rsp_ready  input  1  consumer takes response
rsp_f  output  DATA_W  captured result
rsp_flags  output  6  captured flags {e,l,g,o,c,z}; z is bit0
busy  output  1  high in WAIT or RESP

Behaviour:
Clock and reset:
- Single clock clk; rst is synchronous and active-high.
- rst has priority over every other event, including mid-operation: state goes to IDLE and the in-flight op is discarded.
- Reset values: alu_a=0, alu_b=0, alu_s3..s0=0, rsp_valid=0, rsp_f=0, rsp_flags=0, busy=0, wait counter=0.
- cmd_ready = (state==IDLE) && !rst, so it is 0 while rst is high.

FSM states are IDLE, WAIT and RESP.
- IDLE: on cmd_valid && cmd_ready at an edge:
  - register cmd_a→alu_a, cmd_b→alu_b, cmd_op→alu_s3..s0;
  - load counter=WAIT_CYCLES;
  - go to WAIT.
- WAIT:
  - counter!=0: decrement.
  - counter==0: capture alu_f→rsp_f and {alu_e,alu_l,alu_g,alu_o,alu_c,alu_z}→rsp_flags, set rsp_valid=1, go to RESP.
- RESP:
  - rsp_valid stays high, and rsp_f/rsp_flags are stable, until rsp_ready.
  - On rsp_valid && rsp_ready: clear rsp_valid and go to IDLE.
  - rsp_ready while rsp_valid=0 has no effect.

Timing and throughput:
- alu_a, alu_b and alu_s* stay unchanged from accept until the next accept. The ALU flags are combinational from these lines and stay valid at capture.
- Latency: accept edge to rsp_valid high is WAIT_CYCLES+2 edges; with the default, rsp_valid rises 3 edges after the accept.
- No overlap: at most one op in flight. Peak throughput is one op per WAIT_CYCLES+3 cycles with rsp_ready tied high.
- cmd_valid held during WAIT/RESP is ignored, and the command is not consumed.
- cmd_op values are passed through without decoding; every value is legal.
- No arithmetic is done in the sequencer; widths pass straight through.

Optional Feature:
ALU_CHAIN_EN
- Defined:
  - Adds input port cmd_chain (1 bit).
  - If cmd_chain=1 at accept, alu_a loads the last captured rsp_f instead of cmd_a; cmd_a is ignored.
  - The last-result register resets to 0, so a chained op issued first after reset uses A=0.
  - The last-result register updates at every capture, even before the response is consumed.
- Undefined: the cmd_chain port is absent and alu_a always loads cmd_a.

Decomposition:
Shared package alu_seq_pkg holds:
- the state enum (IDLE, WAIT, RESP);
- OP_W=4;
- flag-index constants FLAG_Z=0, FLAG_C=1, FLAG_O=2, FLAG_G=3, FLAG_L=4, FLAG_E=5.

No sub-module. The FSM, counter and capture registers fit in one module.

Test Plan:
All scenarios use the real ALU top or a stub that registers F one cycle after A/B.
- cmd_a=0x12, cmd_b=0x34, op=add, rsp_ready=1 → alu_a=0x12, alu_b=0x34 held; rsp_valid rises 3 edges after accept; rsp_f=0x46; z=0, c=0.
- add with A=0xFF, B=0x01 → rsp_f=0x00, rsp_flags[FLAG_Z]=1, rsp_flags[FLAG_C]=1, FLAG_G=1.
- rsp_ready held 0 for 10 cycles after rsp_valid → rsp_valid, rsp_f and rsp_flags stable; cmd_ready=0; a second cmd_valid is not accepted until a rsp_ready pulse, after which cmd_ready=1 the next cycle.
- rst asserted for one cycle in WAIT → next cycle rsp_valid=0, all alu_* outputs=0, cmd_ready=1; no response is ever produced for the aborted op.
- A=B=0x55, any op → rsp_flags[FLAG_E]=1, G=0, L=0. Then A=0x10, B=0x20 → L=1.
- With ALU_CHAIN_EN: add 0x03+0x04 (rsp_f=0x07), then chained add with B=0x01 and cmd_a=0xAA → alu_a=0x07, rsp_f=0x08.
